// File: rtl/ram_arbiter_rr.sv
// ram_arbiter_rr
// Two-master round-robin arbiter and access sequencer for an 8-bit
// single-port synchronous RAM with a registered read port. Requests from
// master 0 and master 1 are serialised onto the one RAM port.
// A valid access walks IDLE -> ISSUE -> CAPTURE -> DONE (4 cycles).
// An out-of-range access walks IDLE -> DONE (2 cycles) and never touches the RAM.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/req1               request from master 0 / master 1
//   we0/we1                 1 = write, 0 = read
//   addr0/addr1             request address
//   wdata0/wdata1           write data
//   ack0/ack1               one-cycle completion pulse (DONE state)
//   err0/err1               address out of range, valid with ack
//   gnt0/gnt1               master owns the RAM, ISSUE through DONE
//   rdata                   shared response data, valid while ack is high
//   busy                    sequencer not idle
//   mem_addr/mem_wdata/mem_we  RAM port
//   mem_rdata               RAM registered read data
// All outputs are registered.
module ram_arbiter_rr #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;  // 1 = master 1 was granted last
    logic              sel_q, sel_d;                // master currently being served
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              busy_q, busy_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Winner selection in IDLE: a lone request wins outright; on a tie the
    // master that was not granted last wins.
    logic              pick_s;
    logic              we_sel_s;
    logic [ADDR_W-1:0] addr_sel_s;
    logic [DATA_W-1:0] wdata_sel_s;

    // Combinational arbitration and operand mux for the IDLE decision
    always_comb begin
        if (req0 && req1) begin
            pick_s = ~last_grant_q;
        end else begin
            pick_s = req1;
        end
        we_sel_s    = pick_s ? we1    : we0;
        addr_sel_s  = pick_s ? addr1  : addr0;
        wdata_sel_s = pick_s ? wdata1 : wdata0;
    end

    // Next-state and registered-output computation for the access sequencer
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        mem_we_d     = mem_we_q;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    last_grant_d = pick_s;
                    sel_d        = pick_s;
                    if (addr_sel_s >= DEPTH_A) begin
                        // Rejected without touching the RAM; ack and err go
                        // out together in the DONE cycle.
                        rdata_d = {DATA_W{1'b0}};
                        if (pick_s) begin
                            ack1_d = 1'b1;
                            err1_d = 1'b1;
                        end else begin
                            ack0_d = 1'b1;
                            err0_d = 1'b1;
                        end
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d  = addr_sel_s;
                        mem_wdata_d = wdata_sel_s;
                        mem_we_d    = we_sel_s;
                        if (pick_s) begin
                            gnt1_d = 1'b1;
                        end else begin
                            gnt0_d = 1'b1;
                        end
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // RAM commits at the edge closing this cycle; one-cycle write enable.
                mem_we_d = 1'b0;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: begin
                // The RAM's registered output is valid now (written word on a write).
                rdata_d = mem_rdata;
                if (sel_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                err0_d  = 1'b0;
                err1_d  = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                ack0_d   = 1'b0;
                ack1_d   = 1'b0;
                err0_d   = 1'b0;
                err1_d   = 1'b0;
                gnt0_d   = 1'b0;
                gnt1_d   = 1'b0;
                mem_we_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears the RAM strobe at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            busy_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            rdata_q      <= {DATA_W{1'b0}};
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            busy_q       <= busy_d;
            mem_we_q     <= mem_we_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = busy_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Self-checking bench for ram_arbiter_rr: directed scenarios followed by
// randomized request rounds, checked against a transaction-level model
// (arbitration order, expected latency, and an expected-memory array).
module tb_ram_arbiter_rr;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, err0, err1, gnt0, gnt1, busy;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    ram_arbiter_rr #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // RAM stub: write-first, registered read, preloaded on the first edge.
    logic [7:0] ram [0:10];
    bit         preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 10; i++) ram[i] <= 8'(90 - 10 * i);
            ram[10]   <= 8'd101;
            preloaded <= 1'b1;
            mem_rdata <= 8'd0;
        end else if (mem_we && mem_addr < 8'd11) begin
            ram[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
        end else if (mem_addr < 8'd11) begin
            mem_rdata <= ram[mem_addr];
        end else begin
            mem_rdata <= 8'd0;
        end
    end

    // Reference model state
    logic [7:0] exp_mem [0:10];
    int         last_w;       // master granted last (1 after reset)
    int         we_cycles;    // cycles with mem_we high
    bit         gnt1_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Continuous observers: grant exclusivity, write-strobe cycles, master-1 grant.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt_onehot", 32'(gnt0 && gnt1), 32'd0);
            if (mem_we) we_cycles++;
            if (gnt1) gnt1_seen = 1'b1;
        end
    end

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(ack0 || ack1) && cyc < 12);
    endtask

    // Check one completion for master m against the model, then retire its request.
    task automatic service(input int m, input bit w, input logic [7:0] a,
                           input logic [7:0] d, input int exp_lat);
        int         cyc;
        bit         bad;
        logic [7:0] exp_rd;
        bad = (a >= 8'd11);
        exp_rd = bad ? 8'd0 : (w ? d : exp_mem[a]);
        wait_ack(cyc);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("ack_who", 32'({ack1, ack0}), (m == 1) ? 32'd2 : 32'd1);
        chk("err", 32'({err1, err0}), bad ? ((m == 1) ? 32'd2 : 32'd1) : 32'd0);
        chk("gnt_at_ack", 32'({gnt1, gnt0}), bad ? 32'd0 : ((m == 1) ? 32'd2 : 32'd1));
        chk("rdata", 32'(rdata), 32'(exp_rd));
        if (w && !bad) exp_mem[a] = d;
        last_w = m;
        if (m == 1) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // One arbitration round from IDLE; r0/r1 select which masters request.
    task automatic round(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        int first;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        first = (r0 && r1) ? (1 - last_w) : (r0 ? 0 : 1);
        if (first == 0) service(0, w0, a0, d0, (a0 >= 8'd11) ? 1 : 3);
        else            service(1, w1, a1, d1, (a1 >= 8'd11) ? 1 : 3);
        if (r0 && r1) begin
            if (first == 0) service(1, w1, a1, d1, (a1 >= 8'd11) ? 2 : 4);
            else            service(0, w0, a0, d0, (a0 >= 8'd11) ? 2 : 4);
        end
        @(negedge clk);
        chk("idle_ack", 32'({ack1, ack0}), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 10; i++) exp_mem[i] = 8'(90 - 10 * i);
        exp_mem[10] = 8'd101;
        last_w = 1; we_cycles = 0; gnt1_seen = 1'b0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'd0; addr1 = 8'd0; wdata0 = 8'd0; wdata1 = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({ack0, ack1, err0, err1, gnt0, gnt1, busy, mem_we}), 32'd0);
        chk("rst_data", 32'({rdata, mem_addr, mem_wdata}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Master 0 reads addr 3
        round(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0);
        chk("gnt1_never", 32'(gnt1_seen), 32'd0);

        // Master 1 writes 0xAA to addr 5, then reads it back
        we_cycles = 0;
        round(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd5, 8'd0, 8'hAA);
        chk("we_one_cycle", 32'(we_cycles), 32'd1);
        round(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd5, 8'd0, 8'd0);

        // Simultaneous requests, two transactions each: order 0,1,0,1
        round(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 8'd0);
        round(1'b1, 1'b1, 1'b1, 1'b0, 8'd7, 8'd7, 8'h3C, 8'd0);

        // Out-of-range write, then read of the last populated word
        we_cycles = 0;
        round(1'b1, 1'b0, 1'b1, 1'b0, 8'd11, 8'd0, 8'h77, 8'd0);
        chk("oor_no_we", 32'(we_cycles), 32'd0);
        round(1'b1, 1'b0, 1'b0, 1'b0, 8'd10, 8'd0, 8'd0, 8'd0);

        // Reset asserted during ISSUE of a write of 0x55 to addr 2
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'd2; wdata0 = 8'h55;
        @(posedge clk);
        #2;
        chk("issue_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drops_we", 32'(mem_we), 32'd0);
        chk("rst_drops_gnt", 32'(gnt0), 32'd0);
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_w = 1;
        repeat (2) begin
            @(negedge clk);
            chk("no_abort_ack", 32'({ack1, ack0}), 32'd0);
        end
        round(1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd4, 8'd0, 8'd0);

        // Master 0 holds req through DONE: back-to-back service
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd3;
        wait_ack(cyc);
        chk("b2b_first_lat", 32'(cyc), 32'd3);
        chk("b2b_first_rd", 32'(rdata), 32'(exp_mem[3]));
        wait_ack(cyc);
        chk("b2b_gap", 32'(cyc), 32'd4);
        chk("b2b_ack0", 32'({ack1, ack0}), 32'd1);
        chk("b2b_second_rd", 32'(rdata), 32'(exp_mem[3]));
        req0 = 1'b0;
        last_w = 0;
        @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Randomized rounds
        for (int n = 0; n < 30; n++) begin
            int mask;
            mask = int'($urandom_range(1, 3));
            round(mask[0], mask[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)),
                  8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
